// File: rtl/lc3_pkg.sv
// LC-3 datapath shared constants.
// SR1MUX/DRMUX encodings, special register numbers, NZP one-hot codes.
package lc3_pkg;

  localparam logic [1:0] SR1MUX_IR11_9 = 2'b00;
  localparam logic [1:0] SR1MUX_IR8_6  = 2'b01;
  localparam logic [1:0] SR1MUX_SP     = 2'b10;
  localparam logic [1:0] SR1MUX_R0     = 2'b11;

  localparam logic [1:0] DRMUX_IR11_9 = 2'b00;
  localparam logic [1:0] DRMUX_R7     = 2'b01;
  localparam logic [1:0] DRMUX_SP     = 2'b10;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_SP = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

endpackage

// File: rtl/lc3_reg_file_if.sv
// Register-file bundle: write port, CC load, SR1/SR2 select, debug read.
// master = datapath/controller side, slave = register file.
interface lc3_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              ld_reg;
  logic [AW-1:0]     dr;
  logic [DATA_W-1:0] bus;
  logic              ld_cc;
  logic [1:0]        sr1mux;
  logic [AW-1:0]     ir11to9;
  logic [AW-1:0]     ir8to6;
  logic [AW-1:0]     sr2;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic              n;
  logic              z;
  logic              p;
  logic [AW-1:0]     dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output ld_reg, dr, bus, ld_cc,
    output sr1mux, ir11to9, ir8to6, sr2,
    output dbg_sel,
    input  sr1_out, sr2_out,
    input  n, z, p, dbg_data
  );

  modport slave (
    input  ld_reg, dr, bus, ld_cc,
    input  sr1mux, ir11to9, ir8to6, sr2,
    input  dbg_sel,
    output sr1_out, sr2_out,
    output n, z, p, dbg_data
  );
endinterface

// File: rtl/lc3_cc_gen.sv
// Combinational condition-code generator: bus -> one-hot {n,z,p}.
// in: bus[DATA_W]; out: nzp[3].
module lc3_cc_gen
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] bus,
  output logic [2:0]        nzp
);

  always_comb begin
    nzp = CC_P;
    unique case (1'b1)
      bus[DATA_W-1]: nzp = CC_N;
      (bus == '0):   nzp = CC_Z;
      default:       nzp = CC_P;
    endcase
  end

endmodule

// File: rtl/lc3_reg_file.sv
// LC-3 R0-R7 register file with SR1MUX, optional write bypass and NZP reg.
// ports: clk, rst_n (async low), rf (slave bundle: write/read/CC/debug).
module lc3_reg_file
  import lc3_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst_n,
  lc3_reg_file_if.slave rf
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [2:0]        nzp_q;
  logic [2:0]        nzp_d;
  logic [AW-1:0]     sr1_addr;
  logic              hit1;
  logic              hit2;

  always_comb begin
    sr1_addr = rf.ir11to9;
    unique case (rf.sr1mux)
      SR1MUX_IR11_9: sr1_addr = rf.ir11to9;
      SR1MUX_IR8_6:  sr1_addr = rf.ir8to6;
      SR1MUX_SP:     sr1_addr = AW'(REG_SP);
      SR1MUX_R0:     sr1_addr = AW'(REG_R0);
      default:       sr1_addr = rf.ir11to9;
    endcase
  end

  // forwarding is gated on ld_reg so an idle dr/bus never leaks through
  assign hit1 = (BYPASS != 0) && rf.ld_reg
              && (sr1_addr == rf.dr);
  assign hit2 = (BYPASS != 0) && rf.ld_reg
              && (rf.sr2 == rf.dr);

  assign rf.sr1_out  = hit1 ? rf.bus
                            : regs[sr1_addr];
  assign rf.sr2_out  = hit2 ? rf.bus
                            : regs[rf.sr2];
  assign rf.dbg_data = regs[rf.dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (rf.ld_reg) begin
      regs[rf.dr] <= rf.bus;
    end
  end

  lc3_cc_gen #(
    .DATA_W (DATA_W)
  ) u_cc_gen (
    .bus (rf.bus),
    .nzp (nzp_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nzp_q <= CC_Z;
    else if (rf.ld_cc)
      nzp_q <= nzp_d;
  end

  assign rf.n = nzp_q[2];
  assign rf.z = nzp_q[1];
  assign rf.p = nzp_q[0];

endmodule
